// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Holds the operands for LAT settle cycles, then returns the result on a valid/ready channel.
module alu_arbiter #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [7:0]       req_op,
    output logic [3:0]       alu_A,
    output logic [3:0]       alu_B,
    output logic [3:0]       alu_aluop,
    input  logic [3:0]       alu_y0,
    input  logic [3:0]       alu_y1,
    input  logic [1:0]       alu_ov,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [3:0]       resp_y0,
    output logic [3:0]       resp_y1,
    output logic [1:0]       resp_ov,
    output logic             resp_err,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Both channels: a transfer happens in any cycle where valid and ready are high together.
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0]       LAT_L   = 4'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [3:0]       settle_q, settle_d;
    logic             id_q, id_d;
    logic [3:0]       a_q, a_d, b_q, b_d, op_q, op_d;
    logic [3:0]       y0_q, y0_d, y1_q, y1_d;
    logic [1:0]       ov_q, ov_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic             gnt_v;
    logic             gnt_id;
    logic [3:0]       gnt_a, gnt_b, gnt_op;

    // With both requesting, rr_q picks; otherwise the lone requester wins.
    always_comb begin
        gnt_v  = |req_valid;
        gnt_id = (&req_valid) ? rr_q : req_valid[1];
        gnt_a  = gnt_id ? req_a[7:4]  : req_a[3:0];
        gnt_b  = gnt_id ? req_b[7:4]  : req_b[3:0];
        gnt_op = gnt_id ? req_op[7:4] : req_op[3:0];
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        settle_d  = settle_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        ov_d      = ov_q;
        err_d     = err_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt_v) begin
                    req_ready = gnt_id ? 2'b10 : 2'b01;
                    id_d      = gnt_id;
                    rr_d      = ~gnt_id;
                    a_d       = gnt_a;
                    b_d       = gnt_b;
                    op_d      = gnt_op;
                    if (gnt_op[3:1] == 3'b111) begin
                        // Opcodes 1110/1111 have no ALU function: answer at once.
                        err_d   = 1'b1;
                        y0_d    = 4'd0;
                        y1_d    = 4'd0;
                        ov_d    = 2'd0;
                        state_d = RESP;
                    end else begin
                        settle_d = LAT_L;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) begin
                    y0_d    = alu_y0;
                    y1_d    = alu_y1;
                    ov_d    = alu_ov;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    if (id_q) cnt1_d = cnt1_q + CNT_ONE;
                    else      cnt0_d = cnt0_q + CNT_ONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            settle_q <= 4'd0;
            id_q     <= 1'b0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 4'd0;
            y0_q     <= 4'd0;
            y1_q     <= 4'd0;
            ov_q     <= 2'd0;
            err_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            settle_q <= settle_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            ov_q     <= ov_d;
            err_q    <= err_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_aluop  = op_q;
    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_y0    = y0_q;
    assign resp_y1    = y1_q;
    assign resp_ov    = ov_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != IDLE);
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule
